imem_uart_loader: RTL and testbench

//  Sequences instruction-memory reprogramming over UART and arbitrates the single IMEM port between fetch and loader.

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_word_packer.sv | 55 +++++
 rtl/imem_uart_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_uart_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the UART IMEM loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int LEN_W = 16;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t ST_IDLE  = 3'd0;
  localparam loader_state_t ST_LEN0  = 3'd1;
  localparam loader_state_t ST_LEN1  = 3'd2;
  localparam loader_state_t ST_DATA  = 3'd3;
  localparam loader_state_t ST_CHK   = 3'd4;
  localparam loader_state_t ST_FLUSH = 3'd5;
  localparam loader_state_t ST_ERR   = 3'd6;

  typedef enum logic [1:0] {
    ERR_ABORT   = 2'd0,
    ERR_BAD_LEN = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_BAD_CHK = 2'd3
  } err_code_t;

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_word_packer
// Description : Packs received bytes little-endian into 32-bit words and
//               keeps a running XOR checksum of every byte accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_ready_o,
  output logic [31:0] word_o,
  output logic [7:0]  chk_o
);

  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;
  logic [7:0]  chk_q;
  logic        ready_q;

  // The assembled word stays stable during the write cycle: the next byte
  // can only land in lane 0 at the end of that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      chk_q      <= 8'd0;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= valid_i && !clear_i && (byte_idx_q == 2'd3);
      if (clear_i) begin
        byte_idx_q <= 2'd0;
        word_q     <= 32'd0;
        chk_q      <= 8'd0;
      end else if (valid_i) begin
        word_q[{byte_idx_q, 3'b000} +: 8] <= byte_i;
        chk_q      <= chk_q ^ byte_i;
        byte_idx_q <= byte_idx_q + 2'd1;
      end
    end
  end

  assign last_byte_o  = (byte_idx_q == 2'd3);
  assign word_ready_o = ready_q;
  assign word_o       = word_q;
  assign chk_o        = chk_q;

endmodule
`default_nettype wire

// File: rtl/imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_uart_loader
// Description : Reprograms instruction memory from a UART byte stream and
//               arbitrates the single IMEM port between fetch and loader.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS  = 1024,
  parameter int TIMEOUT_CYC = 1_000_000
)
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        prog_req_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  input  logic        fetch_en_i,
  input  logic [31:0] fetch_addr_i,
  output logic        imem_en_o,
  output logic [3:0]  imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_din_o,
  output logic        memcon_prog_ena_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  loader_state_t    state_q, state_d;
  logic             prog_req_q;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [LEN_W-1:0] n_q, n_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic [TO_W-1:0]  to_q, to_d;
  err_code_t        err_code_q, err_code_d;

  logic             w_pk_clear;
  logic             w_pk_valid;
  logic             w_last_byte;
  logic             w_word_ready;
  logic [31:0]      w_word;
  logic [7:0]       w_chk;
  logic [LEN_W-1:0] w_len;
  logic             w_loader_owns;
  logic             w_write;

  imem_word_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (w_pk_clear),
    .valid_i      (w_pk_valid),
    .byte_i       (rx_data_i),
    .last_byte_o  (w_last_byte),
    .word_ready_o (w_word_ready),
    .word_o       (w_word),
    .chk_o        (w_chk)
  );

  assign w_len = {rx_data_i, len_lo_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    n_d        = n_q;
    word_idx_d = w_word_ready ? word_idx_q + LEN_W'(1) : word_idx_q;
    err_code_d = err_code_q;
    to_d       = '0;
    w_pk_clear = 1'b0;
    w_pk_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (prog_req_i && !prog_req_q) state_d = ST_LEN0;
      end
      ST_LEN0, ST_LEN1, ST_DATA, ST_CHK: begin
        to_d = rx_valid_i ? '0 : to_q + TO_W'(1);
        // Abort wins over a byte arriving in the same cycle.
        if (!prog_req_i) begin
          state_d    = ST_ERR;
          err_code_d = ERR_ABORT;
        end else if (rx_valid_i) begin
          case (state_q)
            ST_LEN0: begin
              len_lo_d = rx_data_i;
              state_d  = ST_LEN1;
            end
            ST_LEN1: begin
              if ((w_len == '0) || (32'(w_len) > 32'(IMEM_WORDS))) begin
                state_d    = ST_ERR;
                err_code_d = ERR_BAD_LEN;
              end else begin
                n_d        = w_len;
                word_idx_d = '0;
                w_pk_clear = 1'b1;
                state_d    = ST_DATA;
              end
            end
            ST_DATA: begin
              w_pk_valid = 1'b1;
              if (w_last_byte && (word_idx_q == n_q - LEN_W'(1))) state_d = ST_CHK;
            end
            default: begin
              if (rx_data_i == w_chk) begin
                state_d = ST_FLUSH;
              end else begin
                state_d    = ST_ERR;
                err_code_d = ERR_BAD_CHK;
              end
            end
          endcase
        end else if (to_d == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d    = ST_ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      ST_ERR: begin
        if (!prog_req_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      prog_req_q <= 1'b0;
      len_lo_q   <= 8'd0;
      n_q        <= '0;
      word_idx_q <= '0;
      to_q       <= '0;
      err_code_q <= ERR_ABORT;
    end else begin
      state_q    <= state_d;
      prog_req_q <= prog_req_i;
      len_lo_q   <= len_lo_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      to_q       <= to_d;
      err_code_q <= err_code_d;
    end
  end

  // The last word's write may fall in CHK/FLUSH/ERR; it is still issued.
  assign w_loader_owns = (state_q != ST_IDLE);
  assign w_write       = w_loader_owns && w_word_ready;

  assign imem_en_o   = w_loader_owns ? w_write : fetch_en_i;
  assign imem_we_o   = w_write ? 4'hF : 4'h0;
  assign imem_addr_o = w_loader_owns ? 32'({word_idx_q, 2'b00}) : fetch_addr_i;
  assign imem_din_o  = w_write ? w_word : 32'd0;

  assign memcon_prog_ena_o = w_loader_owns;
  assign busy_o            = w_loader_owns;
  assign done_o            = (state_q == ST_FLUSH);
  assign err_o             = (state_q == ST_ERR);
  assign err_code_o        = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_uart_loader
// Description : Self-checking bench for imem_uart_loader with a frame-level
//               reference model and table-driven cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_uart_loader;

  localparam int IMEM_WORDS  = 32;
  localparam int TIMEOUT_CYC = 64;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        prog_req_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        fetch_en_i;
  logic [31:0] fetch_addr_i;
  logic        imem_en_o;
  logic [3:0]  imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_din_o;
  logic        memcon_prog_ena_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  imem_uart_loader #(.IMEM_WORDS(IMEM_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .prog_req_i        (prog_req_i),
    .rx_valid_i        (rx_valid_i),
    .rx_data_i         (rx_data_i),
    .fetch_en_i        (fetch_en_i),
    .fetch_addr_i      (fetch_addr_i),
    .imem_en_o         (imem_en_o),
    .imem_we_o         (imem_we_o),
    .imem_addr_o       (imem_addr_o),
    .imem_din_o        (imem_din_o),
    .memcon_prog_ena_o (memcon_prog_ena_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .err_code_o        (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         n;
    bit         fixed;
    logic [7:0] flip;
    int         gap;
    logic       exp_done;
    logic [1:0] exp_code;
  } frame_vec_t;

  typedef struct {
    logic        fe;
    logic [31:0] fa;
    logic [7:0]  rxd;
    logic        exp_en;
    logic [31:0] exp_addr;
  } mux_vec_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_wr_dut = 0;
  int          n_wr_exp = 0;
  int          pend_g;
  int          gap_max_g;
  logic [31:0] cur_w   [IMEM_WORDS] = '{default: 32'd0};
  logic [31:0] mdl_mem [IMEM_WORDS] = '{default: 32'd0};
  logic [31:0] dut_ram [IMEM_WORDS] = '{default: 32'd0};

  // Captures every write the DUT issues to the memory port.
  always @(posedge clk_i) begin
    if (imem_we_o != 4'h0) begin
      n_wr_dut++;
      if (int'(imem_addr_o >> 2) < IMEM_WORDS) dut_ram[int'(imem_addr_o >> 2)] = imem_din_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle; pw is the word index whose write is expected this cycle.
  task automatic step(input logic v, input logic [7:0] d, input int pw);
    rx_valid_i = v;
    rx_data_i  = d;
    @(negedge clk_i);
    if (pw >= 0) begin
      check("write_we", 32'(imem_we_o), 32'hF);
      check("write_addr", imem_addr_o, 32'(pw * 4));
      check("write_data", imem_din_o, cur_w[pw]);
    end else begin
      check("no_write_we", 32'(imem_we_o), 32'h0);
      check("no_write_din", imem_din_o, 32'h0);
    end
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int wr_after);
    int g;
    g = $urandom_range(0, gap_max_g);
    for (int i = 0; i < g; i++) begin
      step(1'b0, 8'h00, pend_g);
      pend_g = -1;
    end
    step(1'b1, d, pend_g);
    pend_g = wr_after;
  endtask

  task automatic start_load();
    prog_req_i = 1'b1;
    step(1'b0, 8'h00, -1);
    check("start_prog_ena", 32'(memcon_prog_ena_o), 32'd1);
    check("start_busy", 32'(busy_o), 32'd1);
  endtask

  task automatic run_case(input frame_vec_t v);
    logic [31:0] w;
    logic [7:0]  chk;
    logic [15:0] n16;
    n16       = 16'(v.n);
    gap_max_g = v.gap;
    pend_g    = -1;
    chk       = 8'h00;
    start_load();
    send(n16[7:0], -1);
    send(n16[15:8], -1);
    if (v.n >= 1 && v.n <= IMEM_WORDS) begin
      for (int i = 0; i < v.n; i++) begin
        if (v.fixed) w = (i == 0) ? 32'h0000_0013 : 32'h00A0_0093;
        else         w = $urandom;
        cur_w[i]   = w;
        mdl_mem[i] = w;
        n_wr_exp++;
        for (int b = 0; b < 4; b++) begin
          chk ^= w[8*b +: 8];
          send(w[8*b +: 8], (b == 3) ? i : -1);
        end
      end
      send(chk ^ v.flip, -1);
    end
    check("end_done", 32'(done_o), 32'(v.exp_done));
    check("end_err", 32'(err_o), 32'(!v.exp_done));
    if (!v.exp_done) check("end_err_code", 32'(err_code_o), 32'(v.exp_code));
    check("end_prog_ena", 32'(memcon_prog_ena_o), 32'd1);
    step(1'b0, 8'h00, -1);
    check("after_done_low", 32'(done_o), 32'd0);
    check("after_prog_ena", 32'(memcon_prog_ena_o), 32'(!v.exp_done));
    check("after_err_hold", 32'(err_o), 32'(!v.exp_done));
    prog_req_i = 1'b0;
    step(1'b0, 8'h00, -1);
    check("release_busy", 32'(busy_o), 32'd0);
    check("release_err", 32'(err_o), 32'd0);
  endtask

  frame_vec_t fv[9];
  mux_vec_t   mv[4];

  initial begin
    logic [31:0] w;
    int          wr_before;

    fv[0] = '{n: 2,              fixed: 1'b1, flip: 8'h00, gap: 1, exp_done: 1'b1, exp_code: 2'd0};
    fv[1] = '{n: 2,              fixed: 1'b1, flip: 8'h07, gap: 1, exp_done: 1'b0, exp_code: 2'd3};
    fv[2] = '{n: 0,              fixed: 1'b0, flip: 8'h00, gap: 0, exp_done: 1'b0, exp_code: 2'd1};
    fv[3] = '{n: IMEM_WORDS + 1, fixed: 1'b0, flip: 8'h00, gap: 2, exp_done: 1'b0, exp_code: 2'd1};
    fv[4] = '{n: IMEM_WORDS,     fixed: 1'b0, flip: 8'h00, gap: 0, exp_done: 1'b1, exp_code: 2'd0};
    for (int i = 5; i < 9; i++) begin
      fv[i].n        = $urandom_range(1, 6);
      fv[i].fixed    = 1'b0;
      fv[i].flip     = (i == 7) ? 8'($urandom_range(1, 255)) : 8'h00;
      fv[i].gap      = $urandom_range(0, 3);
      fv[i].exp_done = (fv[i].flip == 8'h00);
      fv[i].exp_code = 2'd3;
    end

    mv[0] = '{fe: 1'b1, fa: 32'h0000_0010, rxd: 8'h55, exp_en: 1'b1, exp_addr: 32'h0000_0010};
    mv[1] = '{fe: 1'b0, fa: 32'h0000_0020, rxd: 8'hA5, exp_en: 1'b0, exp_addr: 32'h0000_0020};
    mv[2] = '{fe: 1'b1, fa: 32'hFFFF_FFFC, rxd: 8'h01, exp_en: 1'b1, exp_addr: 32'hFFFF_FFFC};
    w     = $urandom & 32'hFFFF_FFFC;
    mv[3] = '{fe: 1'b1, fa: w, rxd: 8'hFF, exp_en: 1'b1, exp_addr: w};

    rst_i        = 1'b1;
    prog_req_i   = 1'b0;
    rx_valid_i   = 1'b0;
    rx_data_i    = 8'h00;
    fetch_en_i   = 1'b0;
    fetch_addr_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_prog_ena", 32'(memcon_prog_ena_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_err_code", 32'(err_code_o), 32'd0);
    check("rst_we", 32'(imem_we_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Idle port mux: fetch owns the port and received bytes are ignored.
    for (int i = 0; i < 4; i++) begin
      fetch_en_i   = mv[i].fe;
      fetch_addr_i = mv[i].fa;
      rx_valid_i   = 1'b1;
      rx_data_i    = mv[i].rxd;
      @(negedge clk_i);
      check("idle_en", 32'(imem_en_o), 32'(mv[i].exp_en));
      check("idle_addr", imem_addr_o, mv[i].exp_addr);
      check("idle_we", 32'(imem_we_o), 32'd0);
      check("idle_din", imem_din_o, 32'd0);
      check("idle_busy", 32'(busy_o), 32'd0);
      @(posedge clk_i);
      #1;
    end
    rx_valid_i = 1'b0;
    check("idle_write_count", 32'(n_wr_dut), 32'd0);

    for (int i = 0; i < 9; i++) run_case(fv[i]);

    // Abort mid-DATA, with a byte arriving in the abort cycle.
    gap_max_g = 0;
    pend_g    = -1;
    start_load();
    send(8'd3, -1);
    send(8'd0, -1);
    for (int i = 0; i < 2; i++) begin
      w          = $urandom;
      cur_w[i]   = w;
      if (i == 0) begin
        mdl_mem[0] = w;
        n_wr_exp++;
      end
      for (int b = 0; b < ((i == 0) ? 4 : 2); b++) send(w[8*b +: 8], (i == 0 && b == 3) ? 0 : -1);
    end
    prog_req_i = 1'b0;
    step(1'b1, 8'hAA, pend_g);
    check("abort_err", 32'(err_o), 32'd1);
    check("abort_code", 32'(err_code_o), 32'd0);
    check("abort_prog_ena", 32'(memcon_prog_ena_o), 32'd1);
    step(1'b0, 8'h00, -1);
    check("abort_exit_busy", 32'(busy_o), 32'd0);
    check("abort_exit_prog_ena", 32'(memcon_prog_ena_o), 32'd0);

    // Timeout after 5 data bytes: only word 0 reaches memory.
    pend_g = -1;
    start_load();
    send(8'd2, -1);
    send(8'd0, -1);
    w          = $urandom;
    cur_w[0]   = w;
    mdl_mem[0] = w;
    n_wr_exp++;
    for (int b = 0; b < 4; b++) send(w[8*b +: 8], (b == 3) ? 0 : -1);
    send(8'h5A, -1);
    for (int k = 1; k < TIMEOUT_CYC; k++) begin
      if (k == TIMEOUT_CYC - 1) check("timeout_not_yet", 32'(err_o), 32'd0);
      step(1'b0, 8'h00, -1);
    end
    check("timeout_err", 32'(err_o), 32'd1);
    check("timeout_code", 32'(err_code_o), 32'd2);
    prog_req_i = 1'b0;
    step(1'b0, 8'h00, -1);
    check("timeout_exit_busy", 32'(busy_o), 32'd0);

    // Async reset just after the 4th byte of a word: no write may follow.
    pend_g = -1;
    start_load();
    send(8'd2, -1);
    send(8'd0, -1);
    w = $urandom;
    for (int b = 0; b < 3; b++) send(w[8*b +: 8], -1);
    wr_before  = n_wr_dut;
    check("pre_rst_code", 32'(err_code_o), 32'd2);
    rx_valid_i = 1'b1;
    rx_data_i  = w[31:24];
    #1;
    rst_i      = 1'b1;
    prog_req_i = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_prog_ena", 32'(memcon_prog_ena_o), 32'd0);
    check("async_rst_err", 32'(err_o), 32'd0);
    check("async_rst_code", 32'(err_code_o), 32'd0);
    check("async_rst_done", 32'(done_o), 32'd0);
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step(1'b0, 8'h00, -1);
    step(1'b0, 8'h00, -1);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    check("post_rst_no_write", 32'(n_wr_dut), 32'(wr_before));

    check("write_count", 32'(n_wr_dut), 32'(n_wr_exp));
    for (int i = 0; i < IMEM_WORDS; i++) check("imem_contents", dut_ram[i], mdl_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
